// File: rtl/video_tpg_axis_if.sv
// ---------------------------------------------------------------------------
// video_tpg_axis_if
// AXI4-Stream video bus carrying one beat of PPC pixels.
//   tdata  : beat payload (TDATA_W bits)
//   tvalid : beat present
//   tready : sink accepts the beat
//   tuser  : start of frame (first beat of a frame)
//   tlast  : end of line (last beat of a line)
// Modports: master (source side), slave (sink side).
// ---------------------------------------------------------------------------
interface video_tpg_axis_if #(
   parameter int TDATA_W = 24
);
   logic [TDATA_W-1:0] tdata;
   logic               tvalid;
   logic               tready;
   logic               tuser;
   logic               tlast;

   modport master (output tdata, output tvalid, output tuser, output tlast, input tready);
   modport slave  (input tdata, input tvalid, input tuser, input tlast, output tready);
endinterface

// File: rtl/video_tpg_axis.sv
// ---------------------------------------------------------------------------
// video_tpg_axis
// Video test-pattern generator with an AXI4-Stream master output.
// Produces frames of ACTIVE_WIDTH x ACTIVE_HEIGHT pixels, PPC pixels per beat,
// one beat per cycle while the sink is ready.
//
// Ports
//   clk, rst_n        : clock (rising edge), synchronous active-low reset
//   enable            : run request; a frame in flight always completes
//   tpg_mode          : pattern select (0 chess, 1 x, 2 y, 3 x+fcnt, 4 y+fcnt,
//                       5 solid, 6 colour bars, others black)
//   ACTIVE_WIDTH      : pixels per line (multiple of PPC)
//   ACTIVE_HEIGHT     : lines per frame
//   solid_color       : per-channel colour for mode 5
//   m_axis            : stream output (tuser = start of frame, tlast = end of line)
//   busy              : high while a frame is being generated
//   frame_done        : one-cycle pulse after the last beat of a frame is taken
//   fcnt_out          : frame counter, wraps at 16 bits
//
// Build option
//   TPG_MOTION_EN : when defined, modes 3/4 add the frame counter to x/y so the
//                   pattern scrolls; when undefined they degenerate to modes 1/2.
// ---------------------------------------------------------------------------
module video_tpg_axis #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_CH     = 3,
   parameter int PPC        = 1,
   parameter int CHESS_WPOW = 4,
   parameter int CHESS_HPOW = 4,
   parameter int BAR_WPOW   = 7
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         enable,
   input  logic [3:0]                   tpg_mode,
   input  logic [15:0]                  ACTIVE_WIDTH,
   input  logic [15:0]                  ACTIVE_HEIGHT,
   input  logic [NUM_CH*DATA_WIDTH-1:0] solid_color,
   video_tpg_axis_if.master             m_axis,
   output logic                         busy,
   output logic                         frame_done,
   output logic [15:0]                  fcnt_out
);

   localparam int PIX_W  = NUM_CH * DATA_WIDTH;
   localparam int BEAT_W = PPC * PIX_W;
   localparam int PPC_SH = $clog2(PPC);

   typedef enum logic {IDLE, RUN} state_t;

   state_t              state_q, state_d;
   logic [15:0]         aw_q, aw_d;
   logic [15:0]         ah_q, ah_d;
   logic [3:0]          mode_q, mode_d;
   logic [PIX_W-1:0]    solid_q, solid_d;
   logic [15:0]         xb_q, xb_d;
   logic [15:0]         y_q, y_d;
   logic [15:0]         fcnt_q, fcnt_d;
   logic [BEAT_W-1:0]   tdata_q, tdata_d;
   logic                tvalid_q, tvalid_d;
   logic                tuser_q, tuser_d;
   logic                tlast_q, tlast_d;
   logic                fdone_q, fdone_d;

   // Coordinates/config of the beat being loaded this cycle.
   logic                load;
   logic [15:0]         gen_xb, gen_y, gen_aw, gen_offs, px;
   logic [3:0]          gen_mode;
   logic [PIX_W-1:0]    gen_solid;
   logic                start_ok, frame_end;

   // One channel value of one pixel; results are truncated to DATA_WIDTH.
   function automatic logic [DATA_WIDTH-1:0] chan_value(
      input logic [15:0]           x,
      input logic [15:0]           y,
      input logic [15:0]           offs,
      input logic [3:0]            mode,
      input logic [DATA_WIDTH-1:0] solid_c,
      input int                    c
   );
      logic [31:0] acc;
      logic [2:0]  bar;
      acc = '0;
      // Bars run white..black left to right: index 7 minus bar number mod 8.
      bar = 3'd7 - 3'(x >> BAR_WPOW);
      case (mode)
         4'd0:    acc = (x[CHESS_WPOW] == y[CHESS_HPOW]) ? '1 : '0;
         4'd1:    acc = {16'd0, x};
         4'd2:    acc = {16'd0, y};
         4'd3:    acc = {16'd0, x} + {16'd0, offs};
         4'd4:    acc = {16'd0, y} + {16'd0, offs};
         4'd5:    acc[DATA_WIDTH-1:0] = solid_c;
         4'd6:    acc = bar[c % 3] ? '1 : '0;
         default: acc = '0;
      endcase
      return acc[DATA_WIDTH-1:0];
   endfunction

   assign start_ok  = enable && (ACTIVE_WIDTH >= 16'(PPC)) && (ACTIVE_HEIGHT != 16'd0);
   assign frame_end = tlast_q && (y_q == ah_q - 16'd1);

   always_comb begin
      state_d   = state_q;
      aw_d      = aw_q;
      ah_d      = ah_q;
      mode_d    = mode_q;
      solid_d   = solid_q;
      xb_d      = xb_q;
      y_d       = y_q;
      fcnt_d    = fcnt_q;
      tdata_d   = tdata_q;
      tvalid_d  = tvalid_q;
      tuser_d   = tuser_q;
      tlast_d   = tlast_q;
      fdone_d   = 1'b0;
      load      = 1'b0;
      gen_xb    = 16'd0;
      gen_y     = 16'd0;
      gen_aw    = aw_q;
      gen_mode  = mode_q;
      gen_solid = solid_q;
      gen_offs  = 16'd0;
      px        = 16'd0;

      case (state_q)
         IDLE: begin
            if (start_ok) begin
               state_d = RUN;
               load    = 1'b1;
            end
         end
         RUN: begin
            if (tvalid_q && m_axis.tready) begin
               if (frame_end) begin
                  fdone_d = 1'b1;
                  fcnt_d  = fcnt_q + 16'd1;
                  if (start_ok) begin
                     load = 1'b1;
                  end else begin
                     state_d  = IDLE;
                     tvalid_d = 1'b0;
                     tuser_d  = 1'b0;
                     tlast_d  = 1'b0;
                  end
               end else begin
                  load = 1'b1;
                  if (tlast_q) begin
                     gen_y = y_q + 16'd1;
                  end else begin
                     gen_xb = xb_q + 16'd1;
                     gen_y  = y_q;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A load at (0,0) is a frame start: take a fresh copy of the config.
      if (load && gen_xb == 16'd0 && gen_y == 16'd0) begin
         aw_d      = ACTIVE_WIDTH;
         ah_d      = ACTIVE_HEIGHT;
         mode_d    = tpg_mode;
         solid_d   = solid_color;
         gen_aw    = ACTIVE_WIDTH;
         gen_mode  = tpg_mode;
         gen_solid = solid_color;
      end

      // Without motion the offset is a constant zero, so the adders fold away.
`ifdef TPG_MOTION_EN
      gen_offs = fcnt_d;
`else
      gen_offs = 16'd0;
`endif

      if (load) begin
         xb_d     = gen_xb;
         y_d      = gen_y;
         tvalid_d = 1'b1;
         tuser_d  = (gen_xb == 16'd0) && (gen_y == 16'd0);
         tlast_d  = (gen_xb == (gen_aw >> PPC_SH) - 16'd1);
         for (int p = 0; p < PPC; p++) begin
            px = (gen_xb << PPC_SH) + 16'(p);
            for (int c = 0; c < NUM_CH; c++) begin
               tdata_d[(p*NUM_CH+c)*DATA_WIDTH +: DATA_WIDTH] =
                  chan_value(px, gen_y, gen_offs, gen_mode,
                             gen_solid[c*DATA_WIDTH +: DATA_WIDTH], c);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         xb_q     <= '0;
         y_q      <= '0;
         fcnt_q   <= '0;
         tdata_q  <= '0;
         tvalid_q <= 1'b0;
         tuser_q  <= 1'b0;
         tlast_q  <= 1'b0;
         fdone_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         xb_q     <= xb_d;
         y_q      <= y_d;
         fcnt_q   <= fcnt_d;
         tdata_q  <= tdata_d;
         tvalid_q <= tvalid_d;
         tuser_q  <= tuser_d;
         tlast_q  <= tlast_d;
         fdone_q  <= fdone_d;
      end
   end

   // Frame configuration is only consumed after a load, so it needs no reset.
   always_ff @(posedge clk) begin
      aw_q    <= aw_d;
      ah_q    <= ah_d;
      mode_q  <= mode_d;
      solid_q <= solid_d;
   end

   assign m_axis.tdata  = tdata_q;
   assign m_axis.tvalid = tvalid_q;
   assign m_axis.tuser  = tuser_q;
   assign m_axis.tlast  = tlast_q;
   assign busy          = (state_q == RUN);
   assign frame_done    = fdone_q;
   assign fcnt_out      = fcnt_q;

endmodule

// File: tb/tb_video_tpg_axis.sv
// ---------------------------------------------------------------------------
// tb_video_tpg_axis
// Bench for video_tpg_axis: a default-parameter instance (PPC=1) and a
// two-pixel-per-beat instance with narrow colour bars. Expected beats come
// from a pixel-level reference model queued per frame.
// ---------------------------------------------------------------------------
module tb_video_tpg_axis;

   typedef struct {
      logic [47:0] d;
      logic        u;
      logic        l;
      logic        fin;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        en1, en2;
   logic        tready;
   logic [3:0]  tpg_mode;
   logic [15:0] active_width, active_height;
   logic [23:0] solid_color;
   logic        busy1, busy2, fd1, fd2;
   logic [15:0] fcnt1, fcnt2;

   logic        which;
   logic [47:0] mon_d;
   logic        mon_v, mon_u, mon_l, mon_fd, mon_busy;

   int          n_tests = 0;
   int          n_fail  = 0;
   beat_t       exp_q[$];
   logic [47:0] acc_q[$];

   video_tpg_axis_if #(.TDATA_W(24)) ax1 ();
   video_tpg_axis_if #(.TDATA_W(48)) ax2 ();

   assign ax1.tready = tready;
   assign ax2.tready = tready;

   video_tpg_axis dut (
      .clk(clk), .rst_n(rst_n), .enable(en1), .tpg_mode(tpg_mode),
      .ACTIVE_WIDTH(active_width), .ACTIVE_HEIGHT(active_height),
      .solid_color(solid_color), .m_axis(ax1),
      .busy(busy1), .frame_done(fd1), .fcnt_out(fcnt1)
   );

   video_tpg_axis #(.PPC(2), .BAR_WPOW(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .enable(en2), .tpg_mode(tpg_mode),
      .ACTIVE_WIDTH(active_width), .ACTIVE_HEIGHT(active_height),
      .solid_color(solid_color), .m_axis(ax2),
      .busy(busy2), .frame_done(fd2), .fcnt_out(fcnt2)
   );

   always #5 clk = ~clk;

   always_comb begin
      if (which) begin
         mon_d = ax2.tdata;  mon_v = ax2.tvalid; mon_u = ax2.tuser;
         mon_l = ax2.tlast;  mon_fd = fd2;       mon_busy = busy2;
      end else begin
         mon_d = {24'd0, ax1.tdata}; mon_v = ax1.tvalid; mon_u = ax1.tuser;
         mon_l = ax1.tlast;          mon_fd = fd1;       mon_busy = busy1;
      end
   end

   // Reference pixel channel value, straight from the pattern definitions.
   function automatic logic [7:0] ref_chan(input int x, input int y, input int f,
                                           input int mode, input logic [23:0] solid,
                                           input int c, input int barw);
      int b;
      case (mode)
         0: return ((((x >> 4) & 1) == ((y >> 4) & 1))) ? 8'hFF : 8'h00;
         1: return 8'(x);
         2: return 8'(y);
`ifdef TPG_MOTION_EN
         3: return 8'(x + f);
         4: return 8'(y + f);
`else
         3: return 8'(x);
         4: return 8'(y);
`endif
         5: return solid[c*8 +: 8];
         6: begin
            b = 7 - ((x >> barw) & 7);
            return (((b >> (c % 3)) & 1) == 1) ? 8'hFF : 8'h00;
         end
         default: return 8'h00;
      endcase
   endfunction

   task automatic build_frame(input int w, input int h, input int mode,
                              input logic [23:0] solid, input int f,
                              input int ppc, input int barw);
      beat_t e;
      for (int y = 0; y < h; y++) begin
         for (int xb = 0; xb < w / ppc; xb++) begin
            e.d = '0;
            for (int p = 0; p < ppc; p++)
               for (int c = 0; c < 3; c++)
                  e.d[(p*3+c)*8 +: 8] = ref_chan(xb*ppc+p, y, f, mode, solid, c, barw);
            e.u   = (xb == 0 && y == 0);
            e.l   = (xb == w / ppc - 1);
            e.fin = e.l && (y == h - 1);
            exp_q.push_back(e);
         end
      end
   endtask

   // Raise enable for the selected instance; the first beat is loaded on the
   // edge that follows.
   task automatic start_run();
      @(posedge clk); #1;
      if (which) en2 = 1'b1; else en1 = 1'b1;
      @(posedge clk); #1;
   endtask

   // Consume beats until the expected queue is drained, checking data,
   // markers, stall stability and frame_done; enable is dropped after beat
   // drop_at is accepted, so the generator must end up idle.
   task automatic monitor(input string tag, input int ready_pct,
                          input int drop_at, input int budget);
      int cyc = 0;
      int nacc = 0;
      bit prev_fin = 0, prev_stall = 0, done = 0, drop = 0, acc;
      logic [47:0] sd = '0;
      logic su = 1'b0, sl = 1'b0;
      beat_t e;
      acc_q.delete();
      forever begin
         @(negedge clk);
         n_tests++;
         if (mon_fd !== prev_fin) begin
            n_fail++;
            $display("FAIL %s frame_done: got %b expected %b (beat %0d)", tag, mon_fd, prev_fin, nacc);
         end
         if (prev_stall) begin
            n_tests++;
            if (mon_v !== 1'b1 || mon_d !== sd || mon_u !== su || mon_l !== sl) begin
               n_fail++;
               $display("FAIL %s stall_hold: got v=%b d=%h u=%b l=%b expected v=1 d=%h u=%b l=%b",
                        tag, mon_v, mon_d, mon_u, mon_l, sd, su, sl);
            end
         end
         if (done) begin
            n_tests++;
            if (mon_v !== 1'b0 || mon_busy !== 1'b0) begin
               n_fail++;
               $display("FAIL %s idle_after_frame: got tvalid=%b busy=%b expected 0 0", tag, mon_v, mon_busy);
            end
            break;
         end
         if (cyc >= budget) begin
            n_tests++; n_fail++;
            $display("FAIL %s timeout: got %0d beats, %0d still expected", tag, nacc, exp_q.size());
            break;
         end
         cyc++;
         acc = mon_v && tready;
         prev_fin = 0;
         if (acc) begin
            if (exp_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL %s extra_beat: got %h expected none", tag, mon_d);
               break;
            end
            e = exp_q.pop_front();
            n_tests++;
            if (mon_d !== e.d || mon_u !== e.u || mon_l !== e.l) begin
               n_fail++;
               $display("FAIL %s beat %0d: got d=%h u=%b l=%b expected d=%h u=%b l=%b",
                        tag, nacc, mon_d, mon_u, mon_l, e.d, e.u, e.l);
            end
            acc_q.push_back(mon_d);
            prev_fin = e.fin;
            if (nacc == drop_at) drop = 1;
            nacc++;
            if (exp_q.size() == 0) done = 1;
         end
         prev_stall = mon_v && !tready;
         sd = mon_d; su = mon_u; sl = mon_l;
         @(posedge clk); #1;
         if (drop) begin
            if (which) en2 = 1'b0; else en1 = 1'b0;
         end
         tready = ($urandom_range(0, 99) < ready_pct);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; en1 = 1'b0; en2 = 1'b0; tready = 1'b1; which = 1'b0;
      tpg_mode = 4'd1; active_width = 16'd8; active_height = 16'd4; solid_color = 24'h123456;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++; if (ax1.tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_tvalid: got %b expected 0", ax1.tvalid); end
      n_tests++; if (ax1.tuser !== 1'b0) begin n_fail++; $display("FAIL rst_tuser: got %b expected 0", ax1.tuser); end
      n_tests++; if (ax1.tlast !== 1'b0) begin n_fail++; $display("FAIL rst_tlast: got %b expected 0", ax1.tlast); end
      n_tests++; if (ax1.tdata !== 24'd0) begin n_fail++; $display("FAIL rst_tdata: got %h expected 0", ax1.tdata); end
      n_tests++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy1); end
      n_tests++; if (fd1 !== 1'b0) begin n_fail++; $display("FAIL rst_frame_done: got %b expected 0", fd1); end
      n_tests++; if (fcnt1 !== 16'd0) begin n_fail++; $display("FAIL rst_fcnt: got %0d expected 0", fcnt1); end
      @(posedge clk); #1 rst_n = 1'b1;
   endtask

   task automatic test_no_start();
      active_width = 16'd0; active_height = 16'd4; en1 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (ax1.tvalid !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL nostart_w0: got tvalid=%b busy=%b expected 0 0", ax1.tvalid, busy1);
      end
      active_width = 16'd8; active_height = 16'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (ax1.tvalid !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++; $display("FAIL nostart_h0: got tvalid=%b busy=%b expected 0 0", ax1.tvalid, busy1);
      end
      en1 = 1'b0; active_height = 16'd4;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      which = 1'b0; tready = 1'b1; tpg_mode = 4'd1;
      active_width = 16'd8; active_height = 16'd4;
      build_frame(8, 4, 1, solid_color, int'(fcnt1), 1, 7);
      start_run();
      monitor("basic", 100, 0, 200);
      n_tests++;
      if (fcnt1 !== 16'd1) begin n_fail++; $display("FAIL basic_fcnt: got %0d expected 1", fcnt1); end
   endtask

   task automatic test_stall();
      which = 1'b0; tpg_mode = 4'd1;
      build_frame(8, 4, 1, solid_color, int'(fcnt1), 1, 7);
      tready = $urandom_range(0, 1);
      start_run();
      monitor("stall", 50, 0, 600);
   endtask

   task automatic test_bars_ppc2();
      which = 1'b1; tready = 1'b1; tpg_mode = 4'd6;
      active_width = 16'd16; active_height = 16'd2;
      build_frame(16, 2, 6, solid_color, 0, 2, 2);
      start_run();
      monitor("bars", 100, 0, 200);
      n_tests++;
      if (acc_q.size() < 3 || acc_q[0] !== 48'hFFFFFF_FFFFFF || acc_q[2] !== 48'hFFFF00_FFFF00) begin
         n_fail++;
         $display("FAIL bars_fixed: got %0d beats b0=%h b2=%h expected b0=ffffffffffff b2=ffff00ffff00",
                  acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 48'd0, (acc_q.size() > 2) ? acc_q[2] : 48'd0);
      end
      which = 1'b0;
   endtask

   task automatic test_enable_drop();
      which = 1'b0; tready = 1'b1; tpg_mode = 4'd2; solid_color = 24'($urandom);
      active_width = 16'd8; active_height = 16'd4;
      build_frame(8, 4, 2, solid_color, int'(fcnt1), 1, 7);
      start_run();
      tpg_mode = 4'd1;  // mid-frame change must not take effect
      monitor("endrop", 100, 10, 200);
   endtask

   task automatic test_motion();
      rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      which = 1'b0; tready = 1'b1; tpg_mode = 4'd3;
      active_width = 16'd8; active_height = 16'd4;
      for (int f = 0; f < 3; f++) build_frame(8, 4, 3, solid_color, f, 1, 7);
      start_run();
      monitor("motion", 100, 67, 300);
      n_tests++;
`ifdef TPG_MOTION_EN
      if (acc_q.size() < 65 || acc_q[64] !== 48'h020202) begin
         n_fail++; $display("FAIL motion_f2: got %h expected 020202", (acc_q.size() > 64) ? acc_q[64] : 48'hx);
      end
`else
      if (acc_q.size() < 65 || acc_q[64] !== 48'h000000) begin
         n_fail++; $display("FAIL motion_f2: got %h expected 000000", (acc_q.size() > 64) ? acc_q[64] : 48'hx);
      end
`endif
   endtask

   task automatic test_reset_mid();
      which = 1'b0; tready = 1'b1; tpg_mode = 4'd5; solid_color = 24'($urandom);
      active_width = 16'd8; active_height = 16'd4;
      start_run();
      repeat (4) @(posedge clk);
      #1 tready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (ax1.tvalid !== 1'b0 || fcnt1 !== 16'd0 || ax1.tuser !== 1'b0 || busy1 !== 1'b0) begin
         n_fail++;
         $display("FAIL midrst: got tvalid=%b fcnt=%0d tuser=%b busy=%b expected 0 0 0 0",
                  ax1.tvalid, fcnt1, ax1.tuser, busy1);
      end
      @(posedge clk); #1;
      rst_n = 1'b1; tready = 1'b1; tpg_mode = 4'd1;
      build_frame(8, 4, 1, solid_color, 0, 1, 7);
      @(posedge clk); #1;
      monitor("restart", 100, 0, 200);
   endtask

   initial begin
      test_reset();
      test_no_start();
      test_basic();
      test_stall();
      test_bars_ppc2();
      test_enable_drop();
      test_motion();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
